tt_project_mux: RTL and testbench

//  Parametrised N-slot project multiplexer for the formal/sim harness; it supersedes the fixed per-slot wrappers.

---
 rtl/tt_mux_pkg.sv | 25 ++
 rtl/tt_slot_seq.sv | 80 ++++++++
 rtl/tt_project_mux.sv | 95 +++++++++
 tb/tb_tt_project_mux.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/tt_mux_pkg.sv
// Shared types and slot-bus field offsets for the project multiplexer.
// Slot iw = {uio_in, ui_in, rst_n, clk}; slot ow = {uio_oe, uio_out, uo_out}.
package tt_mux_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAIN = 2'd1,
    RESET = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int CLK_BIT     = 0;
  localparam int RSTN_BIT    = 1;
  localparam int UI_LSB      = 2;
  localparam int UIO_LSB     = 10;
  localparam int UO_LSB      = 0;
  localparam int UIO_OUT_LSB = 8;
  localparam int UIO_OE_LSB  = 16;
  localparam int PAD_W       = 8;

  function automatic int addr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tt_slot_seq.sv
// Slot switch sequencer: drain for one cycle, hold the new slot in reset
// for RST_CYCLES cycles, then run. Owns the reset timer and address latch.
module tt_slot_seq
  import tt_mux_pkg::*;
#(
  parameter int N_PROJ     = 24,
  parameter int RST_CYCLES = 4,
  parameter int AW         = addr_width(N_PROJ)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          sel_valid,
  input  logic [AW-1:0] sel_addr,
  output logic          sel_ready,
  output logic          sel_err,
  output state_t        state,
  output logic [AW-1:0] active_addr,
  output logic          out_load
);

  localparam int CW = $clog2(RST_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(RST_CYCLES);
  localparam logic [AW:0]   N_LIM    = (AW + 1)'(N_PROJ);

  state_t        state_next;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_next;
  logic          accept;
  logic          addr_ok;

  assign sel_ready = (state == IDLE) || (state == RUN);
  assign accept    = sel_valid && sel_ready;
  assign addr_ok   = {1'b0, sel_addr} < N_LIM;

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    case (state)
      IDLE, RUN: begin
        if (accept) begin
          state_next = addr_ok ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        state_next = RESET;
        cnt_next   = CNT_LOAD;
      end
      RESET: begin
        // Terminal count at 1 so the slot sees exactly RST_CYCLES reset cycles.
        if (cnt <= CW'(1)) begin
          state_next = RUN;
        end
        if (cnt != '0) begin
          cnt_next = cnt - CW'(1);
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Pads only follow the slot while it stays in RUN across the edge.
  assign out_load = (state == RUN) && (state_next == RUN);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      active_addr <= '0;
      sel_err     <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      sel_err <= accept && !addr_ok;
      if (accept && addr_ok) begin
        active_addr <= sel_addr;
      end
    end
  end

endmodule

// File: rtl/tt_project_mux.sv
// N-slot project multiplexer: packs pad inputs into the enabled slot's iw bus
// and registers the running slot's ow bus onto the pads.
module tt_project_mux
  import tt_mux_pkg::*;
#(
  parameter int N_PROJ     = 24,
  parameter int IW         = 18,
  parameter int OW         = 24,
  parameter int RST_CYCLES = 4,
  parameter int AW         = addr_width(N_PROJ)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sel_valid,
  input  logic [AW-1:0]        sel_addr,
  output logic                 sel_ready,
  output logic                 sel_err,
  input  logic [7:0]           ui_in,
  input  logic [7:0]           uio_in,
  output logic [7:0]           uo_out,
  output logic [7:0]           uio_out,
  output logic [7:0]           uio_oe,
  output logic [N_PROJ-1:0]    proj_ena,
  output logic [N_PROJ*IW-1:0] proj_iw,
  input  logic [N_PROJ*OW-1:0] proj_ow,
  output logic [AW-1:0]        active_addr,
  output logic                 running
);

  state_t        state;
  logic          out_load;
  logic          slot_ena;
  logic [OW-1:0] sel_ow;

  tt_slot_seq #(
    .N_PROJ    (N_PROJ),
    .RST_CYCLES(RST_CYCLES),
    .AW        (AW)
  ) u_seq (
    .clk        (clk),
    .rst        (rst),
    .sel_valid  (sel_valid),
    .sel_addr   (sel_addr),
    .sel_ready  (sel_ready),
    .sel_err    (sel_err),
    .state      (state),
    .active_addr(active_addr),
    .out_load   (out_load)
  );

  assign running  = (state == RUN);
  assign slot_ena = (state == RESET) || (state == RUN);

  always_comb begin
    proj_ena = '0;
    for (int k = 0; k < N_PROJ; k++) begin
      proj_ena[k] = slot_ena && (active_addr == AW'(k));
    end
  end

  // Non-enabled slots see only the clock; their rst_n stays low.
  always_comb begin
    proj_iw = '0;
    for (int k = 0; k < N_PROJ; k++) begin
      proj_iw[k*IW + CLK_BIT] = clk;
      if (proj_ena[k]) begin
        proj_iw[k*IW + RSTN_BIT]      = running;
        proj_iw[k*IW + UI_LSB +: 8]  = ui_in;
        proj_iw[k*IW + UIO_LSB +: 8] = uio_in;
      end
    end
  end

  always_comb begin
    sel_ow = '0;
    for (int k = 0; k < N_PROJ; k++) begin
      if (active_addr == AW'(k)) begin
        sel_ow = proj_ow[k*OW +: OW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !out_load) begin
      uo_out  <= '0;
      uio_out <= '0;
      uio_oe  <= '0;
    end else begin
      uo_out  <= sel_ow[UO_LSB +: PAD_W];
      uio_out <= sel_ow[UIO_OUT_LSB +: PAD_W];
      uio_oe  <= sel_ow[UIO_OE_LSB +: PAD_W];
    end
  end

endmodule

// File: tb/tb_tt_project_mux.sv
// Bench for tt_project_mux: directed switch scenarios followed by random traffic,
// all checked every cycle against a timeline model of the switch sequence.
module tb_tt_project_mux;
  import tt_mux_pkg::*;

  localparam int N  = 24;
  localparam int IW = 18;
  localparam int OW = 24;
  localparam int RC = 4;
  localparam int AW = 5;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            sel_valid = 1'b0;
  logic [AW-1:0]   sel_addr = '0;
  logic            sel_ready;
  logic            sel_err;
  logic [7:0]      ui_in = '0;
  logic [7:0]      uio_in = '0;
  logic [7:0]      uo_out;
  logic [7:0]      uio_out;
  logic [7:0]      uio_oe;
  logic [N-1:0]    proj_ena;
  logic [N*IW-1:0] proj_iw;
  logic [N*OW-1:0] proj_ow = '0;
  logic [AW-1:0]   active_addr;
  logic            running;

  always #5 clk = ~clk;

  tt_project_mux #(
    .N_PROJ(N), .IW(IW), .OW(OW), .RST_CYCLES(RC), .AW(AW)
  ) dut (
    .clk(clk), .rst(rst), .sel_valid(sel_valid), .sel_addr(sel_addr),
    .sel_ready(sel_ready), .sel_err(sel_err), .ui_in(ui_in), .uio_in(uio_in),
    .uo_out(uo_out), .uio_out(uio_out), .uio_oe(uio_oe), .proj_ena(proj_ena),
    .proj_iw(proj_iw), .proj_ow(proj_ow), .active_addr(active_addr),
    .running(running)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Model: cycle index, and time since the last accepted valid select.
  int          cyc   = 0;
  bit          m_sel = 1'b0;
  int          m_addr = 0;
  int          m_t0  = 0;
  bit          m_err = 1'b0;
  logic [23:0] m_pad = '0;

  function automatic bit m_running();
    return m_sel && ((cyc - m_t0) >= RC + 2);
  endfunction

  function automatic bit m_enabled();
    return m_sel && ((cyc - m_t0) >= 2);
  endfunction

  function automatic bit m_ready();
    return !m_sel || m_running();
  endfunction

  task automatic chk(input string tag, input logic [N*IW-1:0] obs, input logic [N*IW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge();
    bit          was_run;
    bit          acc;
    int          a_in;
    logic [23:0] ow_s;
    was_run = m_running();
    acc     = sel_valid && m_ready();
    a_in    = int'(sel_addr);
    ow_s    = proj_ow[m_addr*OW +: OW];
    cyc++;
    if (rst) begin
      m_sel  = 1'b0;
      m_addr = 0;
      m_err  = 1'b0;
      m_pad  = '0;
    end else begin
      m_err = acc && (a_in >= N);
      if (acc) begin
        if (a_in < N) begin
          m_sel  = 1'b1;
          m_t0   = cyc - 1;
          m_addr = a_in;
        end else begin
          m_sel = 1'b0;
        end
      end
      m_pad = (was_run && m_running()) ? ow_s : 24'h0;
    end
  endtask

  task automatic check_all();
    logic [N-1:0]    e_ena;
    logic [N*IW-1:0] e_iw;
    e_ena = '0;
    e_iw  = '0;
    if (m_enabled()) e_ena[m_addr] = 1'b1;
    for (int k = 0; k < N; k++) begin
      e_iw[k*IW] = clk;
      if (e_ena[k]) e_iw[k*IW +: IW] = {uio_in, ui_in, m_running(), clk};
    end
    chk("sel_ready", sel_ready, m_ready());
    chk("sel_err", sel_err, m_err);
    chk("running", running, m_running());
    chk("active_addr", active_addr, m_addr);
    chk("proj_ena", proj_ena, e_ena);
    chk("pads", {uio_oe, uio_out, uo_out}, m_pad);
    chk("proj_iw", proj_iw, e_iw);
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    check_all();
  endtask

  task automatic randomize_ow();
    for (int k = 0; k < N; k++) proj_ow[k*OW +: OW] = 24'($urandom);
  endtask

  initial begin
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Select slot 3 from idle.
    sel_valid = 1'b1; sel_addr = 5'd3;
    tick();
    sel_valid = 1'b0;
    repeat (4) tick();
    chk("t1_not_yet_running", running, 1'b0);
    tick();
    chk("t1_running_6th", running, 1'b1);
    chk("t1_ena", proj_ena, 24'h8);

    // Slot data reaches pads on the second RUN cycle.
    proj_ow[3*OW +: OW] = 24'hA5_5A_C3;
    ui_in = 8'h3C; uio_in = 8'h96;
    tick();
    chk("t2_uo", uo_out, 8'hC3);
    chk("t2_uio_out", uio_out, 8'h5A);
    chk("t2_uio_oe", uio_oe, 8'hA5);
    chk("t2_other_ui", proj_iw[4*IW + UI_LSB +: 8], 8'h00);

    // Switch 3 -> 7.
    sel_valid = 1'b1; sel_addr = 5'd7;
    tick();
    sel_valid = 1'b0;
    chk("t3_drain_uo", uo_out, 8'h00);
    chk("t3_drain_oe", uio_oe, 8'h00);
    chk("t3_drain_ena", proj_ena, 24'h0);
    tick();
    chk("t3_reset_ena", proj_ena, 24'h80);
    chk("t3_slot3_rstn", proj_iw[3*IW + RSTN_BIT], 1'b0);
    repeat (5) tick();

    // Out-of-range select.
    sel_valid = 1'b1; sel_addr = 5'd30;
    tick();
    sel_valid = 1'b0;
    chk("t4_err", sel_err, 1'b1);
    chk("t4_ena", proj_ena, 24'h0);
    tick();
    chk("t4_err_pulse", sel_err, 1'b0);

    // Reset in the middle of the reset count, then a fresh select.
    sel_valid = 1'b1; sel_addr = 5'd5;
    tick();
    sel_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t5_ready", sel_ready, 1'b1);
    chk("t5_ena", proj_ena, 24'h0);
    sel_valid = 1'b1; sel_addr = 5'd5;
    tick();
    sel_valid = 1'b0;
    repeat (6) tick();

    // Held request with a changing address during a switch.
    sel_valid = 1'b1;
    for (int i = 0; i < 14; i++) begin
      sel_addr = 5'($urandom_range(0, N - 1));
      tick();
    end
    sel_valid = 1'b0;
    repeat (6) tick();

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      randomize_ow();
      ui_in     = 8'($urandom);
      uio_in    = 8'($urandom);
      sel_valid = ($urandom_range(0, 5) == 0);
      sel_addr  = 5'($urandom_range(0, 31));
      rst       = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
